shift_right_seq_32bit: RTL and testbench

//  Multi-cycle right shifter for the MiniMIPS datapath: the right-direction counterpart of the

---
 rtl/shift_right_seq_32bit_pkg.sv | 14 +
 rtl/shift_right_seq_32bit_sr1.sv | 14 +
 rtl/shift_right_seq_32bit.sv | 83 ++++++++
 tb/tb_shift_right_seq_32bit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/shift_right_seq_32bit_pkg.sv
// Shared definitions for the MiniMIPS multi-cycle right shifter:
// state encodings and default widths.
package shift_right_seq_32bit_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_seq_32bit_sr1.sv
// Combinational one-bit right shift with an explicit fill bit entering at the MSB.
module shift_right_1_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = {fill, value[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_right_seq_32bit.sv
// Multi-cycle SRL/SRA unit: shifts one bit per cycle under a start/done handshake.
module shift_right_seq_32bit
    import shift_right_seq_32bit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state;
    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   data_shifted;
    logic [SHAMT_W-1:0] count;
    logic               arith_q;
    logic               fill;

    // Sign fill tracks the current MSB, so SRA of a negative operand saturates to all ones.
    always_comb begin
        fill = arith_q & data[WIDTH-1];
    end

    shift_right_1_32bit #(
        .WIDTH(WIDTH)
    ) u_sr1 (
        .value (data),
        .fill  (fill),
        .result(data_shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            data    <= '0;
            count   <= '0;
            arith_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        data    <= value;
                        count   <= shamt;
                        arith_q <= arith;
                        state   <= ST_SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (count != '0) begin
                        data  <= data_shifted;
                        count <= count - 1'b1;
                    end else begin
                        result <= data;
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq_32bit.sv
// Directed bench for shift_right_seq_32bit with a queue-based scoreboard of results and latencies.
module tb_shift_right_seq_32bit;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_right_seq_32bit #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] s, input logic a);
        if (a) return $signed(v) >>> s;
        return v >> s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic launch(input logic [31:0] v, input logic [4:0] s, input logic a);
        exp_t e;
        start = 1'b1;
        value = v;
        shamt = s;
        arith = a;
        @(posedge clk);
        e.res = ref_shift(v, s, a);
        e.lat = int'(s) + 2;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
    endtask

    // Counts negedges since acceptance until done; optionally pokes a start while busy.
    task automatic wait_done(input string tag, input int poke, output int busy_cycles);
        int   cyc;
        exp_t e;
        cyc = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cycles++;
            if (cyc == poke) begin
                start = 1'b1;
                value = 32'hFFFF_FFFF;
                shamt = 5'd1;
            end else if (cyc == poke + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
            check({tag, "_result"}, result, e.res);
        end
    endtask

    initial begin
        int bc;
        int pulses;
        logic [31:0] held;

        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        shamt = '0;
        arith = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SRL basic
        launch(32'hF000_0000, 5'd4, 1'b0);
        wait_done("srl_basic", -10, bc);
        check("srl_basic_value", result, 32'h0F00_0000);
        @(negedge clk);
        check("srl_done_pulse", 32'(done), 32'd0);

        // SRA negative, maximum shift
        launch(32'h8000_0000, 5'd31, 1'b1);
        wait_done("sra_neg31", -10, bc);
        check("sra_neg31_value", result, 32'hFFFF_FFFF);
        check("sra_neg31_busy_cycles", 32'(bc), 32'd32);
        @(negedge clk);

        // Zero shift
        launch(32'h1234_5678, 5'd0, 1'b0);
        wait_done("zero_shift", -10, bc);
        check("zero_shift_value", result, 32'h1234_5678);
        @(negedge clk);

        // Logical shift of all ones by 31, and SRA of a positive value
        launch(32'hFFFF_FFFF, 5'd31, 1'b0);
        wait_done("srl_ones31", -10, bc);
        @(negedge clk);
        launch(32'h7654_3210, 5'd7, 1'b1);
        wait_done("sra_pos7", -10, bc);
        @(negedge clk);

        // Start while shifting is ignored
        launch(32'hA5A5_0000, 5'd10, 1'b0);
        wait_done("ignored_start", 3, bc);
        held = result;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("ignored_start_extra_done", 32'(pulses), 32'd0);
        check("ignored_start_hold", held, ref_shift(32'hA5A5_0000, 5'd10, 1'b0));
        check("ignored_start_busy_idle", 32'(busy), 32'd0);

        // Back-to-back: second start presented while in DONE
        launch(32'h8000_0001, 5'd3, 1'b1);
        wait_done("b2b_first", -10, bc);
        launch(32'h0000_0100, 5'd8, 1'b0);
        wait_done("b2b_second", -10, bc);
        check("b2b_second_value", result, 32'h0000_0001);
        @(negedge clk);

        // Reset in the middle of a long shift
        launch(32'hDEAD_BEEF, 5'd20, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", result, 32'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("midreset_no_done", 32'(pulses), 32'd0);
        launch(32'hC000_0F00, 5'd5, 1'b1);
        wait_done("after_reset", -10, bc);
        check("after_reset_value", result, 32'hFE00_0078);
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
